i2c_slave_rx: RTL

- Synthesizable write-only I2C slave receiver.
- Sits directly downstream of the bench I2C master model and consumes its scl/sda.
- Synchronizes the bus, detects START/STOP, matches a 7-bit address, ACKs, and deserializes written bytes.
- Presents bytes on a valid/ready interface to the slave register logic.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bus_sync.sv | 56 +++++
 rtl/i2c_slave_rx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the write-only I2C slave
//               receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_BYTE_W = 8;

    // Open-drain levels driven onto SDA during the acknowledge bit
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_ACK  = 3'd4,
        ST_WAIT_STOP = 3'd5
    } i2c_state_t;

endpackage : i2c_pkg

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// Module      : i2c_bus_sync
// Description : Synchronizes asynchronous SCL/SDA into the clk domain and
//               derives SCL edges plus START/STOP bus conditions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_cond,
    output logic stop_cond
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Synchronizer chains plus one history flop per line; idle bus level is 1
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s &  scl_prev_q;

    // SDA transitions only count as bus conditions while SCL has been stably
    // high, so a simultaneous SCL/SDA change is never misread as START/STOP.
    assign start_cond = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_cond  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s & ~start_cond;

endmodule : i2c_bus_sync

`default_nettype wire

// File: rtl/i2c_slave_rx.sv
// ============================================================================
// Module      : i2c_slave_rx
// Description : Write-only I2C slave receiver. Matches a 7-bit address,
//               acknowledges, deserializes written bytes and presents them on
//               a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic       overrun
);

    logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_sample;

    i2c_state_t                state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0]     shift_q, shift_d;
    logic [I2C_BYTE_W-1:0]     w_byte;
    logic                      byte_done_q, byte_done_d;
    logic                      sda_o_q, sda_o_d;
    logic [I2C_BYTE_W-1:0]     rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      start_det_q, start_det_d;
    logic                      stop_det_q, stop_det_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_s      (w_scl_s),
        .sda_s      (w_sda_s),
        .scl_rise   (w_scl_rise),
        .scl_fall   (w_scl_fall),
        .start_cond (w_start),
        .stop_cond  (w_stop)
    );

    // A bit is sampled on the synchronized SCL rising edge
    assign w_sample = w_scl_rise & w_scl_s;
    assign w_byte   = {shift_q[I2C_BYTE_W-2:0], w_sda_s};

    // State and output registers; every output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            sda_o_q     <= I2C_NACK;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            sda_o_q     <= sda_o_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        sda_o_d     = sda_o_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        busy_d      = busy_q;
        overrun_d   = 1'b0;

        if (w_start) begin
            // START or repeated START: any partial byte is abandoned
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            sda_o_d     = I2C_NACK;
            busy_d      = 1'b1;
            start_det_d = 1'b1;
        end else if (w_stop) begin
            // STOP: a byte still awaiting the consumer is kept
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            sda_o_d     = I2C_NACK;
            busy_d      = 1'b0;
            stop_det_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (w_sample) begin
                        shift_d   = w_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (w_scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (shift_q[I2C_BYTE_W-1:1] == SLAVE_ADDR && !shift_q[0]) begin
                            sda_o_d = I2C_ACK;
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // The first falling edge seen here follows the 9th clock
                    if (w_scl_fall) begin
                        sda_o_d = I2C_NACK;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        shift_d   = w_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d   = w_byte;
                                rx_valid_d  = 1'b1;
                                byte_done_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                                state_d   = ST_WAIT_STOP;
                            end
                        end
                    end else if (w_scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_o_d     = I2C_ACK;
                        state_d     = ST_DATA_ACK;
                    end
                end
                ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        sda_o_d = I2C_NACK;
                        state_d = ST_DATA;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_o_d = I2C_NACK;
                end
                default: begin
                    state_d = ST_IDLE;
                    sda_o_d = I2C_NACK;
                end
            endcase
        end
    end

    assign sda_o     = sda_o_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule : i2c_slave_rx

`default_nettype wire
